// File: rtl/seg7_display_sched.sv
// Shares one combinational seg7 decoder across N_DIGITS HEX displays: the loaded value
// is converted to BCD with double-dabble, then each digit is decoded and latched in turn.
module seg7_display_sched #(
  parameter int N_DIGITS = 4,
  parameter int VALUE_W  = 14
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              dec_digit,
  input  logic [6:0]              dec_segments,
  output logic [7*N_DIGITS-1:0]   hex_out
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned MAX_VAL = pow10(N_DIGITS) - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);
  localparam logic [2:0]       IDX_LAST = 3'(N_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, REFRESH} state_t;

  state_t             state, state_next;
  logic [VALUE_W-1:0] bin;
  logic [VALUE_W-1:0] sat_value;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         idx;
  logic               blank_q;
  logic [3:0]         cur_nib;
  logic               upper_zero;
  logic               blank_slot;

  assign busy = (state != IDLE);

  // Values beyond the display range show as all nines instead of wrapping.
  always_comb begin
    sat_value = value;
    if (64'(value) > MAX_VAL) sat_value = VALUE_W'(MAX_VAL);
  end

  always_comb begin
    bcd_adj = bcd;
    for (int j = 0; j < N_DIGITS; j++) begin
      if (bcd[4*j +: 4] >= 4'd5) bcd_adj[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
    end
  end

  // A slot is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    cur_nib    = 4'd0;
    upper_zero = 1'b1;
    for (int j = 0; j < N_DIGITS; j++) begin
      if (3'(j) == idx) cur_nib = bcd[4*j +: 4];
      if (3'(j) >= idx && bcd[4*j +: 4] != 4'd0) upper_zero = 1'b0;
    end
    blank_slot = blank_q && (idx != 3'd0) && upper_zero;
    dec_digit  = (state == REFRESH) ? cur_nib : 4'd0;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CONVERT;
      CONVERT: if (cnt == CNT_LAST) state_next = REFRESH;
      REFRESH: if (idx == IDX_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bin     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      idx     <= '0;
      blank_q <= 1'b0;
      done    <= 1'b0;
      hex_out <= {N_DIGITS{7'h7F}};
    end else begin
      state <= state_next;
      done  <= (state == REFRESH) && (idx == IDX_LAST);
      case (state)
        IDLE: begin
          if (load) begin
            bin     <= sat_value;
            blank_q <= blank_lz;
            bcd     <= '0;
            cnt     <= '0;
            idx     <= '0;
          end
        end
        CONVERT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt        <= cnt + 1'b1;
          idx        <= '0;
        end
        REFRESH: begin
          for (int j = 0; j < N_DIGITS; j++) begin
            if (3'(j) == idx) hex_out[7*j +: 7] <= blank_slot ? 7'h7F : dec_segments;
          end
          idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_display_sched.sv
// Bench for seg7_display_sched with an attached active-low hex decoder and a decimal
// reference model feeding an expected-display queue.
module tb_seg7_display_sched;

  localparam int N_DIGITS = 4;
  localparam int VALUE_W  = 14;
  localparam int LAT      = VALUE_W + N_DIGITS;
  localparam logic [27:0] BLANK_ALL = {4{7'h7F}};
  localparam logic [27:0] HEX_1234  = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

  logic              clock;
  logic              reset;
  logic [VALUE_W-1:0] value;
  logic              load;
  logic              blank_lz;
  logic              busy;
  logic              done;
  logic [3:0]        dec_digit;
  logic [6:0]        dec_segments;
  logic [27:0]       hex_out;

  int checks   = 0;
  int failures = 0;
  logic [27:0] exp_q[$];
  logic [27:0] last_disp;

  seg7_display_sched #(.N_DIGITS(N_DIGITS), .VALUE_W(VALUE_W)) dut (
    .clock(clock), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
    .busy(busy), .done(done), .dec_digit(dec_digit), .dec_segments(dec_segments),
    .hex_out(hex_out)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0011000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  always_comb dec_segments = seg7(dec_digit);

  function automatic logic [27:0] model(input int v, input bit blz);
    logic [27:0] r;
    int s, p, d;
    s = (v > 9999) ? 9999 : v;
    p = 1;
    r = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      d = (s / p) % 10;
      if (blz && i > 0 && s < p) r[7*i +: 7] = 7'h7F;
      else r[7*i +: 7] = seg7(4'(d));
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at the negedge after the load edge
  task automatic do_load(input int v, input bit blz);
    value    = VALUE_W'(v);
    blank_lz = blz;
    load     = 1'b1;
    exp_q.push_back(model(v, blz));
    @(negedge clock);
    load = 1'b0;
    check("busy_rise", busy, 1);
  endtask

  task automatic drop_load(input int v, input bit blz);
    value    = VALUE_W'(v);
    blank_lz = blz;
    load     = 1'b1;
    @(negedge clock);
    load = 1'b0;
    check("busy_hold", busy, 1);
    check("hex_keep", hex_out, last_disp);
  endtask

  task automatic wait_done(input int lat0, input bit chain, input int cv, input bit cblz);
    int lat;
    logic [27:0] e;
    lat = lat0;
    while (done !== 1'b1 && lat < LAT + 40) begin
      @(negedge clock);
      lat++;
    end
    check("latency", lat, LAT);
    if (chain) begin
      value    = VALUE_W'(cv);
      blank_lz = cblz;
      load     = 1'b1;
    end
    check("queue_size", exp_q.size(), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : BLANK_ALL;
    check("hex_out", hex_out, e);
    last_disp = hex_out;
    @(negedge clock);
    if (chain) begin
      load = 1'b0;
      exp_q.push_back(model(cv, cblz));
    end
    check("done_pulse", done, 0);
    check("busy_after", busy, chain);
  endtask

  task automatic expect_no_done(input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (done === 1'b1) pulses++;
    end
    check("extra_done", pulses, 0);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0;
    last_disp = BLANK_ALL;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_hex", hex_out, BLANK_ALL);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dec", dec_digit, 0);

    do_load(1234, 1'b0);
    wait_done(0, 1'b0, 0, 1'b0);
    check("hex_1234", hex_out, HEX_1234);

    do_load(7, 1'b1);
    wait_done(0, 1'b0, 0, 1'b0);
    do_load(0, 1'b1);
    wait_done(0, 1'b0, 0, 1'b0);

    do_load(12000, 1'b0);
    wait_done(0, 1'b0, 0, 1'b0);

    do_load(42, 1'b0);
    repeat (4) @(negedge clock);
    drop_load(99, 1'b0);
    wait_done(5, 1'b0, 0, 1'b0);
    expect_no_done(25);

    do_load(315, 1'b1);
    wait_done(0, 1'b1, 6021, 1'b0);
    wait_done(0, 1'b0, 0, 1'b0);

    do_load(5678, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_hex", hex_out, BLANK_ALL);
    check("abort_busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    last_disp = BLANK_ALL;
    expect_no_done(LAT + 5);
    do_load(5, 1'b0);
    wait_done(0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      do_load(int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)));
      wait_done(0, 1'b0, 0, 1'b0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
